// File: rtl/button_bank_if.sv
// rtl/button_bank_if.sv - push-button bank signal bundle (raw pins in, conditioned levels and strobes out)
interface button_bank_if #(
    parameter int CH = 4
);
    logic [CH-1:0] pb_in;
    logic [CH-1:0] pb_state;
    logic [CH-1:0] pb_down;
    logic [CH-1:0] pb_up;
    logic [CH-1:0] pb_repeat;
    logic          pb_any;

    modport master (
        output pb_in,
        input  pb_state, pb_down, pb_up, pb_repeat, pb_any
    );

    modport slave (
        input  pb_in,
        output pb_state, pb_down, pb_up, pb_repeat, pb_any
    );
endinterface

// File: rtl/button_bank.sv
// rtl/button_bank.sv - multi-channel button synchroniser/debouncer with press/release strobes
// Optional hold-to-repeat strobes are built when BUTTON_BANK_REPEAT_EN is defined.
module button_bank #(
    parameter int CH         = 4,
    parameter int N          = 20,
    parameter int ACTIVE_LOW = 1,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_RATE   = 10_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    button_bank_if.slave bus
);
    logic [CH-1:0] pin_level;
    logic [CH-1:0] sync1;
    logic [CH-1:0] sync2;
    logic [CH-1:0] state;
    logic [CH-1:0] down;
    logic [CH-1:0] up;
    logic [CH-1:0] toggle;
    logic [N-1:0]  cnt [CH];

    // Polarity is normalised before the first flop so everything downstream is active-high.
    assign pin_level = (ACTIVE_LOW != 0) ? ~bus.pb_in : bus.pb_in;

    always_comb begin
        toggle = '0;
        for (int i = 0; i < CH; i++) begin
            toggle[i] = (sync2[i] != state[i]) && (&cnt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            state <= '0;
            down  <= '0;
            up    <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= pin_level;
            sync2 <= sync1;
            state <= state ^ toggle;
            down  <= toggle & ~state;
            up    <= toggle & state;
            for (int i = 0; i < CH; i++) begin
                if ((sync2[i] == state[i]) || toggle[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.pb_state = state;
    assign bus.pb_down  = down;
    assign bus.pb_up    = up;
    assign bus.pb_any   = |state;

`ifdef BUTTON_BANK_REPEAT_EN
    localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(RPT_RATE - 1);

    logic [RW-1:0] rcnt [CH];
    logic [CH-1:0] first;
    logic [CH-1:0] rpt;

    // Clearing on the release toggle keeps a strobe out of the pb_up cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt   <= '0;
            first <= '1;
            for (int i = 0; i < CH; i++) begin
                rcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                rpt[i] <= 1'b0;
                if (!state[i] || toggle[i]) begin
                    rcnt[i]  <= '0;
                    first[i] <= 1'b1;
                end else if (rcnt[i] == (first[i] ? DELAY_LAST : RATE_LAST)) begin
                    rpt[i]   <= 1'b1;
                    rcnt[i]  <= '0;
                    first[i] <= 1'b0;
                end else begin
                    rcnt[i] <= rcnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.pb_repeat = rpt;
`else
    assign bus.pb_repeat = '0;
`endif
endmodule
